// File: rtl/alu_seq.sv
// Sequential, valid/ready handshaked ALU with an iterative shift-add multiplier.
// Optional: define ALU_SEQ_DIV_EN to add unsigned restoring divide on opcode family 0111.

module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         opcode,
  input  logic [WIDTH-1:0]   data_rd,
  input  logic [WIDTH-1:0]   data_rr,
  input  logic               ci,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] data_o,
  output logic               co,
  output logic               zo,
  output logic               no
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    HOLD
  } state_e;

  localparam logic [3:0] FAM_SHIFT = 4'b0000;
  localparam logic [3:0] FAM_MUL   = 4'b0110;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] FAM_DIV   = 4'b0111;
`endif
  localparam logic [3:0] FAM_AND   = 4'b1000;
  localparam logic [3:0] FAM_OR    = 4'b1001;
  localparam logic [3:0] FAM_XOR   = 4'b1010;
  localparam logic [3:0] FAM_NEG   = 4'b1011;
  localparam logic [3:0] FAM_ADD   = 4'b1100;
  localparam logic [3:0] FAM_ADDC  = 4'b1101;
  localparam logic [3:0] FAM_SUB   = 4'b1110;
  localparam logic [3:0] FAM_SUBC  = 4'b1111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic is_iter_fam(input logic [3:0] fam);
    logic r;
    r = (fam == FAM_MUL);
`ifdef ALU_SEQ_DIV_EN
    r = r | (fam == FAM_DIV);
`endif
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           fam_q, fam_d;
  logic [1:0]           kind_q, kind_d;
  logic [WIDTH-1:0]     rd_q, rd_d;
  logic [WIDTH-1:0]     rr_q, rr_d;
  logic                 ci_q, ci_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   data_q, data_d;
  logic                 co_q, co_d;
  logic                 zo_q, zo_d;
  logic                 no_q, no_d;

  logic [WIDTH-1:0]     exec_res;
  logic                 exec_co;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   step_res;
  logic                 step_co;

  // Only the shift kind (opcode[1:0]) is meaningful below the family nibble.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode[3:2];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign data_o    = data_q;
  assign co        = co_q;
  assign zo        = zo_q;
  assign no        = no_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fam_q   <= '0;
      kind_q  <= '0;
      rd_q    <= '0;
      rr_q    <= '0;
      ci_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      co_q    <= 1'b0;
      zo_q    <= 1'b1;
      no_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fam_q   <= fam_d;
      kind_q  <= kind_d;
      rd_q    <= rd_d;
      rr_q    <= rr_d;
      ci_q    <= ci_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      co_q    <= co_d;
      zo_q    <= zo_d;
      no_q    <= no_d;
    end
  end

  // Single-cycle datapath; unknown families leave co untouched and yield zero.
  always_comb begin
    exec_res = '0;
    exec_co  = co_q;
    sum_w    = '0;
    case (fam_q)
      FAM_SHIFT: begin
        case (kind_q)
          2'b00: begin
            exec_res = {rd_q[WIDTH-2:0], 1'b0};
            exec_co  = rd_q[WIDTH-1];
          end
          2'b01: begin
            exec_res = {rd_q[WIDTH-1], rd_q[WIDTH-1:1]};
            exec_co  = rd_q[0];
          end
          2'b10: begin
            exec_res = {rd_q[WIDTH-2:0], ci_q};
            exec_co  = rd_q[WIDTH-1];
          end
          default: begin
            exec_res = {ci_q, rd_q[WIDTH-1:1]};
            exec_co  = rd_q[0];
          end
        endcase
      end
      FAM_AND: begin
        exec_res = rd_q & rr_q;
        exec_co  = 1'b0;
      end
      FAM_OR: begin
        exec_res = rd_q | rr_q;
        exec_co  = 1'b0;
      end
      FAM_XOR: begin
        exec_res = rd_q ^ rr_q;
        exec_co  = 1'b0;
      end
      FAM_NEG: begin
        exec_res = -rd_q;
        exec_co  = |rd_q;
      end
      FAM_ADD: begin
        sum_w    = {1'b0, rd_q} + {1'b0, rr_q};
        exec_res = sum_w[WIDTH-1:0];
        exec_co  = sum_w[WIDTH];
      end
      FAM_ADDC: begin
        sum_w    = {1'b0, rd_q} + {1'b0, rr_q} + (WIDTH+1)'(ci_q);
        exec_res = sum_w[WIDTH-1:0];
        exec_co  = sum_w[WIDTH];
      end
      FAM_SUB: begin
        sum_w    = {1'b0, rd_q} - {1'b0, rr_q};
        exec_res = sum_w[WIDTH-1:0];
        exec_co  = sum_w[WIDTH];
      end
      FAM_SUBC: begin
        // rr+ci never exceeds 2^WIDTH, so bit WIDTH is an exact borrow.
        sum_w    = {1'b0, rd_q} - {1'b0, rr_q} - (WIDTH+1)'(ci_q);
        exec_res = sum_w[WIDTH-1:0];
        exec_co  = sum_w[WIDTH];
      end
      default: begin
        exec_res = '0;
        exec_co  = co_q;
      end
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0] div_rs;
  logic [WIDTH:0] div_diff;
  logic           div_ge;
`endif

  // One iteration step. Multiply: acc = {partial product, multiplier}, shifted right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, rd_q} : '0);
    step_res = {mul_sum, acc_q[WIDTH-1:1]};
    step_co  = step_res[2*WIDTH-1];
`ifdef ALU_SEQ_DIV_EN
    // Divide: acc = {remainder, dividend/quotient}, shifted left one bit per step.
    div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_rs >= {1'b0, rr_q});
    div_diff = div_rs - {1'b0, rr_q};
    if (fam_q == FAM_DIV) begin
      step_res = {(div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
      step_co  = (rr_q == '0);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    fam_d   = fam_q;
    kind_d  = kind_q;
    rd_d    = rd_q;
    rr_d    = rr_q;
    ci_d    = ci_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    co_d    = co_q;
    zo_d    = zo_q;
    no_d    = no_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          fam_d  = opcode[7:4];
          kind_d = opcode[1:0];
          rd_d   = data_rd;
          rr_d   = data_rr;
          ci_d   = ci;
          cnt_d  = '0;
          acc_d  = {{WIDTH{1'b0}}, data_rr};
`ifdef ALU_SEQ_DIV_EN
          if (opcode[7:4] == FAM_DIV) acc_d = {{WIDTH{1'b0}}, data_rd};
`endif
          state_d = is_iter_fam(opcode[7:4]) ? ITER : EXEC;
        end
      end
      EXEC: begin
        data_d  = {{WIDTH{1'b0}}, exec_res};
        co_d    = exec_co;
        zo_d    = (exec_res == '0);
        no_d    = exec_res[WIDTH-1];
        state_d = HOLD;
      end
      ITER: begin
        acc_d = step_res;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          data_d  = step_res;
          co_d    = step_co;
          zo_d    = (step_res == '0);
          no_d    = step_res[2*WIDTH-1];
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
